// File: rtl/imem_loader_pkg.sv
//==============================================================================
// imem_loader_pkg -- loader state encoding and default memory geometry
// Rev 1.0
//==============================================================================
`default_nettype none

package imem_loader_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [2:0] {
      S_LEN  = 3'd0,
      S_DATA = 3'd1,
      S_CHK  = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/imem_ram.sv
//==============================================================================
// imem_ram -- 2**ADDR_W x DATA_W storage, synchronous write, combinational read
// Rev 1.0
//==============================================================================
`default_nettype none

module imem_ram #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   // No reset: program contents survive a loader reset.
   logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
//==============================================================================
// imem_loader -- streams a length-prefixed program into instruction memory and
// holds the CPU in reset until loaded. Optional checksum: IMEM_LOADER_CHECKSUM_EN
// Rev 1.0
//==============================================================================
`default_nettype none

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] read_address,
   output logic [DATA_W-1:0] instruction,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   byte_count
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              load_done_q, load_done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic              load_err_q, load_err_d;
   logic [DATA_W-1:0] csum_q, csum_d;
`endif

   logic              w_active;
   logic              w_xfer;
   logic              w_we;
   logic [ADDR_W:0]   w_n_full;
   logic              w_last;

   assign w_active = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
   // A start pulse or reset on the same cycle must not let a byte slip in.
   assign in_ready = w_active && !start && !reset;
   assign w_xfer   = in_valid && in_ready;

   // Length byte 0 stands for a full memory image.
   assign w_n_full = (len_q == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_q};
   assign w_last   = (cnt_q == (w_n_full - (ADDR_W+1)'(1)));

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      cpu_reset_d = cpu_reset_q;
      load_done_d = load_done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      load_err_d  = load_err_q;
      csum_d      = csum_q;
`endif
      w_we        = 1'b0;

      if (start) begin
         state_d     = S_LEN;
         cnt_d       = '0;
         cpu_reset_d = 1'b1;
         load_done_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         load_err_d  = 1'b0;
         csum_d      = '0;
`endif
      end else if (w_xfer) begin
         case (state_q)
            S_LEN: begin
               len_d   = ADDR_W'(in_data);
               cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = S_DATA;
            end
            S_DATA: begin
               w_we  = 1'b1;
               cnt_d = cnt_q + (ADDR_W+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q + in_data;
               if (w_last) begin
                  state_d = S_CHK;
               end
`else
               if (w_last) begin
                  state_d     = S_DONE;
                  cpu_reset_d = 1'b0;
                  load_done_d = 1'b1;
               end
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (in_data == csum_q) begin
                  state_d     = S_DONE;
                  cpu_reset_d = 1'b0;
                  load_done_d = 1'b1;
               end else begin
                  state_d    = S_ERR;
                  load_err_d = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q     <= S_LEN;
         len_q       <= '0;
         cnt_q       <= '0;
         cpu_reset_q <= 1'b1;
         load_done_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         load_err_q  <= 1'b0;
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         cpu_reset_q <= cpu_reset_d;
         load_done_q <= load_done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         load_err_q  <= load_err_d;
         csum_q      <= csum_d;
`endif
      end
   end

   assign cpu_reset  = cpu_reset_q;
   assign load_done  = load_done_q;
   assign byte_count = cnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign load_err   = load_err_q;
`else
   assign load_err   = 1'b0;
`endif

   imem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk_i   (clk_in),
      .we_i    (w_we),
      .waddr_i (cnt_q[ADDR_W-1:0]),
      .wdata_i (in_data),
      .raddr_i (read_address),
      .rdata_o (instruction)
   );

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//==============================================================================
// tb_imem_loader -- directed vectors for imem_loader, both checksum builds
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_imem_loader;

   logic       clk_in   = 1'b0;
   logic       reset    = 1'b1;
   logic       start    = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic       in_valid = 1'b0;
   logic [7:0] read_address = 8'h00;
   logic       in_ready;
   logic [7:0] instruction;
   logic       cpu_reset;
   logic       load_done;
   logic       load_err;
   logic [8:0] byte_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   imem_loader #(
      .ADDR_W (8),
      .DATA_W (8)
   ) dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .start        (start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .read_address (read_address),
      .instruction  (instruction),
      .cpu_reset    (cpu_reset),
      .load_done    (load_done),
      .load_err     (load_err),
      .byte_count   (byte_count)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t        = 0;
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk_in);
      while (!in_ready && t < 16) begin
         @(negedge clk_in);
         t++;
      end
      if (!in_ready) check_val("rdy_timeout", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_data  = 8'hEE;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic offer_refused(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk_in);
      check_val("refused_rdy", 32'(in_ready), 32'd0);
      tick();
      in_valid = 1'b0;
      in_data  = 8'hEE;
   endtask

   task automatic check_mem(input int a, input logic [7:0] e);
      read_address = 8'(a);
      #1;
      check_val($sformatf("mem[%0d]", a), 32'(instruction), 32'(e));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check_val("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check_val("rst_load_done", 32'(load_done), 32'd0);
      check_val("rst_load_err",  32'(load_err),  32'd0);
      check_val("rst_byte_count", 32'(byte_count), 32'd0);
      check_val("rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk_in);
      check_val("len_in_ready", 32'(in_ready), 32'd1);
      tick();

      // 2-byte program 0xAA,0xBB: done registered one cycle after the last byte
      send_byte(8'h02);
      send_byte(8'hAA);
      in_data  = 8'hBB;
      in_valid = 1'b1;
      @(negedge clk_in);
      check_val("pre_last_done", 32'(load_done), 32'd0);
      check_val("pre_last_rdy",  32'(in_ready),  32'd1);
      tick();
      in_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h65);
`endif
      @(negedge clk_in);
      check_val("p2_done",      32'(load_done),  32'd1);
      check_val("p2_cpu_reset", 32'(cpu_reset),  32'd0);
      check_val("p2_count",     32'(byte_count), 32'd2);
      tick();
      offer_refused(8'h55);
      @(negedge clk_in);
      check_val("p2_count_hold", 32'(byte_count), 32'd2);
      tick();
      check_mem(0, 8'hAA);
      check_mem(1, 8'hBB);

      // start from DONE returns to LEN with CPU held
      pulse_start();
      @(negedge clk_in);
      check_val("restart_cpu_reset", 32'(cpu_reset), 32'd1);
      check_val("restart_done",      32'(load_done), 32'd0);
      check_val("restart_rdy",       32'(in_ready),  32'd1);
      tick();

      // 3-byte program 0x11,0x22,0x33 with checksum 0x66
      send_byte(8'h03);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
`ifdef IMEM_LOADER_CHECKSUM_EN
      @(negedge clk_in);
      check_val("chk_wait_done", 32'(load_done), 32'd0);
      check_val("chk_wait_rdy",  32'(in_ready),  32'd1);
      tick();
      send_byte(8'h66);
`endif
      @(negedge clk_in);
      check_val("p3_done",      32'(load_done),  32'd1);
      check_val("p3_cpu_reset", 32'(cpu_reset),  32'd0);
      check_val("p3_count",     32'(byte_count), 32'd3);
      tick();
      offer_refused(8'h66);
      check_mem(0, 8'h11);
      check_mem(1, 8'h22);
      check_mem(2, 8'h33);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // bad checksum lands in ERR
      pulse_start();
      send_byte(8'h03);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h65);
      @(negedge clk_in);
      check_val("err_flag",      32'(load_err),  32'd1);
      check_val("err_cpu_reset", 32'(cpu_reset), 32'd1);
      check_val("err_rdy",       32'(in_ready),  32'd0);
      check_val("err_done",      32'(load_done), 32'd0);
      tick();
      pulse_start();
      @(negedge clk_in);
      check_val("err_clr_flag", 32'(load_err), 32'd0);
      check_val("err_clr_rdy",  32'(in_ready), 32'd1);
      tick();
`endif

      // in_valid toggling: only handshaken bytes land, in order
      pulse_start();
      send_byte(8'h04);
      for (int i = 0; i < 4; i++) begin
         send_byte(8'hA1 + 8'(i));
         tick();
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h8A);
`endif
      @(negedge clk_in);
      check_val("tog_count", 32'(byte_count), 32'd4);
      check_val("tog_done",  32'(load_done),  32'd1);
      tick();
      for (int i = 0; i < 4; i++) check_mem(i, 8'hA1 + 8'(i));

      // reset mid-load, with a byte offered on the reset edge
      pulse_start();
      send_byte(8'h03);
      send_byte(8'h5A);
      send_byte(8'hA5);
      in_data  = 8'hFF;
      in_valid = 1'b1;
      reset    = 1'b1;
      @(negedge clk_in);
      check_val("rstmid_rdy_in_rst", 32'(in_ready), 32'd0);
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk_in);
      check_val("rstmid_count",     32'(byte_count), 32'd0);
      check_val("rstmid_cpu_reset", 32'(cpu_reset),  32'd1);
      check_val("rstmid_rdy",       32'(in_ready),   32'd1);
      tick();
      check_mem(0, 8'h5A);
      check_mem(1, 8'hA5);
      check_mem(2, 8'hA3);

      // start mid-load refuses the concurrent byte and restarts at LEN
      send_byte(8'h03);
      send_byte(8'h77);
      start    = 1'b1;
      in_data  = 8'h99;
      in_valid = 1'b1;
      @(negedge clk_in);
      check_val("midstart_rdy", 32'(in_ready), 32'd0);
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk_in);
      check_val("midstart_count", 32'(byte_count), 32'd0);
      tick();
      send_byte(8'h01);
      send_byte(8'h42);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h42);
`endif
      @(negedge clk_in);
      check_val("p1_done",  32'(load_done),  32'd1);
      check_val("p1_count", 32'(byte_count), 32'd1);
      tick();
      check_mem(0, 8'h42);
      check_mem(1, 8'hA5);

      // full image: length 0 means 256 bytes
      pulse_start();
      send_byte(8'h00);
      for (int i = 0; i < 255; i++) send_byte(8'h01);
      @(negedge clk_in);
      check_val("full_count_255", 32'(byte_count), 32'd255);
      check_val("full_done_early", 32'(load_done), 32'd0);
      tick();
      send_byte(8'h01);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h00);
`endif
      @(negedge clk_in);
      check_val("full_count", 32'(byte_count), 32'd256);
      check_val("full_done",  32'(load_done),  32'd1);
      check_val("full_cpu_reset", 32'(cpu_reset), 32'd0);
      tick();
      for (int i = 0; i < 256; i++) check_mem(i, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
